// File: rtl/aes_key_sched_ctrl.sv
// AES key-expansion sequencer: walks word index i over the key schedule,
// tracks i mod Nk, chooses the per-word transform, handshakes with the
// shared S-box and strobes words into the round-key store.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; conf latched on accept
// LOAD    | copy Nk cipher-key words into slots 0..Nk-1
// CALC    | decide transform for word i from i mod Nk
// WAIT_SB | S-box request outstanding, timeout down-counter running
// WRITE   | store word i, advance rcon after a rot+sub+rcon word
// DONE    | one-cycle completion pulse
module aes_key_sched_ctrl #(
    parameter int ADDR_W     = 6,
    parameter int SB_TIMEOUT = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic [1:0]        conf_in,
    input  logic              sbox_ack_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out,
    output logic              load_out,
    output logic [1:0]        op_out,
    output logic [7:0]        rcon_out,
    output logic              sbox_req_out,
    output logic [ADDR_W-1:0] widx_out,
    output logic [3:0]        imodk_out,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out
);

    localparam int TMO_W = (SB_TIMEOUT > 2) ? $clog2(SB_TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0]  ONE_T = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(SB_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CALC    = 3'd2,
        S_WAIT_SB = 3'd3,
        S_WRITE   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_i;
    logic [3:0]          r_imodk;
    logic [7:0]          r_rcon;
    logic [3:0]          r_nk;
    logic [ADDR_W-1:0]   r_last;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_err;

    state_t              w_nxt_state;
    logic [ADDR_W-1:0]   w_nxt_i;
    logic [3:0]          w_nxt_imodk;
    logic [7:0]          w_nxt_rcon;
    logic [3:0]          w_nxt_nk;
    logic [ADDR_W-1:0]   w_nxt_last;
    logic [TMO_W-1:0]    w_nxt_tmo;
    logic                w_nxt_err;
    logic [1:0]          w_op;
    logic                w_imodk_wrap;
    logic [7:0]          w_xtime;

    // Transform selection; imodk is stable from CALC through WRITE so no op register is needed
    always_comb begin
        w_op = 2'd0;
        if (r_imodk == 4'd0) begin
            w_op = 2'd1;
        end else if (r_nk == 4'd8 && r_imodk == 4'd4) begin
            w_op = 2'd2;
        end
        w_imodk_wrap = (r_imodk == (r_nk - 4'd1));
        w_xtime      = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);
    end

    // State register plus schedule counters
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_imodk <= 4'd0;
            r_rcon  <= 8'h01;
            r_nk    <= 4'd4;
            r_last  <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_i     <= w_nxt_i;
            r_imodk <= w_nxt_imodk;
            r_rcon  <= w_nxt_rcon;
            r_nk    <= w_nxt_nk;
            r_last  <= w_nxt_last;
            r_tmo   <= w_nxt_tmo;
            r_err   <= w_nxt_err;
        end
    end

    // Next-state, counter updates and Moore outputs
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_i      = r_i;
        w_nxt_imodk  = r_imodk;
        w_nxt_rcon   = r_rcon;
        w_nxt_nk     = r_nk;
        w_nxt_last   = r_last;
        w_nxt_tmo    = r_tmo;
        w_nxt_err    = 1'b0;
        busy_out     = (r_state != S_IDLE);
        done_out     = 1'b0;
        err_out      = r_err;
        load_out     = 1'b0;
        op_out       = 2'd0;
        rcon_out     = r_rcon;
        sbox_req_out = 1'b0;
        widx_out     = r_i;
        imodk_out    = r_imodk;
        wr_en_out    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    if (conf_in == 2'd3) begin
                        w_nxt_err = 1'b1;
                    end else begin
                        w_nxt_state = S_LOAD;
                        w_nxt_i     = '0;
                        w_nxt_imodk = 4'd0;
                        w_nxt_rcon  = 8'h01;
                        case (conf_in)
                            2'd0:    begin w_nxt_nk = 4'd4; w_nxt_last = ADDR_W'(43); end
                            2'd1:    begin w_nxt_nk = 4'd6; w_nxt_last = ADDR_W'(51); end
                            default: begin w_nxt_nk = 4'd8; w_nxt_last = ADDR_W'(59); end
                        endcase
                    end
                end
            end
            S_LOAD: begin
                load_out  = 1'b1;
                wr_en_out = 1'b1;
                w_nxt_i   = r_i + ONE_A;
                // i < Nk during LOAD, so imodk equals i and doubles as the load counter
                if (w_imodk_wrap) begin
                    w_nxt_imodk = 4'd0;
                    w_nxt_state = S_CALC;
                end else begin
                    w_nxt_imodk = r_imodk + 4'd1;
                end
            end
            S_CALC: begin
                op_out = w_op;
                if (w_op == 2'd0) begin
                    w_nxt_state = S_WRITE;
                end else begin
                    w_nxt_state = S_WAIT_SB;
                    w_nxt_tmo   = TMO_LOAD;
                end
            end
            S_WAIT_SB: begin
                op_out       = w_op;
                sbox_req_out = 1'b1;
                if (sbox_ack_in) begin
                    w_nxt_state = S_WRITE;
                end else if (r_tmo == '0) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_err   = 1'b1;
                end else begin
                    w_nxt_tmo = r_tmo - ONE_T;
                end
            end
            S_WRITE: begin
                op_out    = w_op;
                wr_en_out = 1'b1;
                if (w_op == 2'd1) begin
                    w_nxt_rcon = w_xtime;
                end
                if (r_i == r_last) begin
                    w_nxt_state = S_DONE;
                end else begin
                    w_nxt_state = S_CALC;
                    w_nxt_i     = r_i + ONE_A;
                    w_nxt_imodk = w_imodk_wrap ? 4'd0 : (r_imodk + 4'd1);
                end
            end
            S_DONE: begin
                done_out    = 1'b1;
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase

        // Abort wins over ack, timeout and completion; counters freeze where they are
        if (r_state != S_IDLE && abort_in) begin
            w_nxt_state = S_IDLE;
            w_nxt_err   = 1'b0;
            w_nxt_i     = r_i;
            w_nxt_imodk = r_imodk;
            w_nxt_rcon  = r_rcon;
        end

        wr_addr_out = wr_en_out ? r_i : '0;
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for the AES key-schedule sequencer. Expected write order, transforms,
// round constants and latencies come from the AES key-expansion rules.
module tb_aes_key_sched_ctrl;

    localparam int ADDR_W = 6;
    localparam int SB_TIMEOUT = 16;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              start_in;
    logic              abort_in;
    logic [1:0]        conf_in;
    logic              sbox_ack_in;
    logic              busy_out;
    logic              done_out;
    logic              err_out;
    logic              load_out;
    logic [1:0]        op_out;
    logic [7:0]        rcon_out;
    logic              sbox_req_out;
    logic [ADDR_W-1:0] widx_out;
    logic [3:0]        imodk_out;
    logic              wr_en_out;
    logic [ADDR_W-1:0] wr_addr_out;

    int n_chk = 0;
    int n_err = 0;

    // AES round constants, one extra entry for words after the last rot+sub+rcon
    logic [7:0] rtab [11] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                              8'h40, 8'h80, 8'h1B, 8'h36, 8'h6C};

    typedef struct {
        int conf;
        int d;       // 0: ack tied high, >0: fixed delay, <0: random
        int wh;      // word index whose ack is withheld, -1 none
        int ab;      // word index at which abort is raised, -1 none
        bit again;   // second start while busy
        bit e_done;
        bit e_err;
        int e_nw;
        int e_cyc;
    } vec_t;

    aes_key_sched_ctrl #(.ADDR_W(ADDR_W), .SB_TIMEOUT(SB_TIMEOUT)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start_in    (start_in),
        .abort_in    (abort_in),
        .conf_in     (conf_in),
        .sbox_ack_in (sbox_ack_in),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .err_out     (err_out),
        .load_out    (load_out),
        .op_out      (op_out),
        .rcon_out    (rcon_out),
        .sbox_req_out(sbox_req_out),
        .widx_out    (widx_out),
        .imodk_out   (imodk_out),
        .wr_en_out   (wr_en_out),
        .wr_addr_out (wr_addr_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    function automatic int exp_op(input int i, input int nk);
        if (i < nk) return 0;
        if (i % nk == 0) return 1;
        if (nk == 8 && i % nk == 4) return 2;
        return 0;
    endfunction

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"},  busy_out, 0);
        chk({tag, "_done"},  done_out, 0);
        chk({tag, "_err"},   err_out, 0);
        chk({tag, "_load"},  load_out, 0);
        chk({tag, "_op"},    op_out, 0);
        chk({tag, "_rcon"},  rcon_out, 8'h01);
        chk({tag, "_req"},   sbox_req_out, 0);
        chk({tag, "_widx"},  widx_out, 0);
        chk({tag, "_imodk"}, imodk_out, 0);
        chk({tag, "_wren"},  wr_en_out, 0);
        chk({tag, "_waddr"}, wr_addr_out, 0);
    endtask

    task automatic run_sched(input int conf, input int d, input int wh, input int ab, input bit again,
                             output bit o_done, output bit o_err, output int o_nw, output int o_cyc);
        int nk, last, nw, cyc, wc, cur_d, dsum, nreq_w, exp_c;
        logic [1:0] cap_op;
        logic [7:0] cap_rc;
        logic [ADDR_W-1:0] cap_wi;
        bit aborted, fin;
        nk = 4 + 2 * conf;
        last = 4 * (nk + 7) - 1;
        exp_c = nk + 1;
        for (int i = nk; i <= last; i++) exp_c += (exp_op(i, nk) == 0) ? 2 : 3;
        nw = 0; cyc = 0; wc = 0; cur_d = 0; dsum = 0; nreq_w = 0;
        aborted = 0; fin = 0; o_done = 0; o_err = 0;
        cap_op = '0; cap_rc = '0; cap_wi = '0;
        @(negedge clk_in);
        conf_in = conf[1:0];
        start_in = 1'b1;
        abort_in = 1'b0;
        sbox_ack_in = (d == 0);
        while (!fin && cyc < 2000) begin
            @(negedge clk_in);
            cyc++;
            if (cyc == 1) begin
                start_in = 1'b0;
                conf_in = 2'($urandom_range(0, 3));
            end
            if (again && cyc == 10) begin start_in = 1'b1; conf_in = 2'd2; end
            if (again && cyc == 11) start_in = 1'b0;
            if (aborted) begin
                abort_in = 1'b0;
                chk("abort_busy", busy_out, 0);
                chk("abort_req", sbox_req_out, 0);
                chk("abort_wren", wr_en_out, 0);
                chk("abort_done", done_out, 0);
                chk("abort_err", err_out, 0);
                fin = 1;
            end else begin
                if (wr_en_out) begin
                    chk("wr_addr", wr_addr_out, nw);
                    chk("widx", widx_out, nw);
                    chk("op", op_out, exp_op(nw, nk));
                    chk("load", load_out, nw < nk);
                    chk("imodk", imodk_out, nw % nk);
                    chk("rcon", rcon_out, (nw < nk) ? 8'h01 : rtab[(nw - 1) / nk]);
                    nw++;
                end
                if (sbox_req_out) begin
                    wc++;
                    if (wc == 1) begin
                        cap_op = op_out; cap_rc = rcon_out; cap_wi = widx_out;
                        chk("req_op", op_out, exp_op(widx_out, nk));
                        cur_d = (d < 0) ? $urandom_range(0, 4) : d;
                        dsum += cur_d;
                    end else begin
                        chk("wait_op_stable", op_out, cap_op);
                        chk("wait_rcon_stable", rcon_out, cap_rc);
                        chk("wait_widx_stable", widx_out, cap_wi);
                    end
                end else begin
                    wc = 0;
                end
                if (sbox_req_out && wh >= 0 && widx_out == wh) begin
                    sbox_ack_in = 1'b0;
                    nreq_w++;
                end else if (d == 0) begin
                    sbox_ack_in = 1'b1;
                end else if (sbox_req_out) begin
                    sbox_ack_in = (wc == cur_d + 1);
                end else begin
                    sbox_ack_in = (d < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                if (done_out) begin
                    o_done = 1; fin = 1;
                    chk("done_nw", nw, last + 1);
                    chk("done_cycle", cyc, exp_c + dsum);
                    chk("done_widx", widx_out, last);
                    chk("done_rcon", rcon_out, rtab[last / nk]);
                    chk("done_busy", busy_out, 1);
                end
                if (err_out) begin
                    o_err = 1; fin = 1;
                    chk("err_busy", busy_out, 0);
                    if (wh >= 0) chk("tmo_wait_cycles", nreq_w, SB_TIMEOUT);
                end
                if (!fin && ab >= 0 && busy_out && widx_out == ab) begin
                    abort_in = 1'b1;
                    aborted = 1;
                end
            end
        end
        if (!fin) begin
            n_chk++; n_err++;
            $display("FAIL sched_budget: got=%0d cycles without end, expected completion", cyc);
        end
        start_in = 1'b0;
        abort_in = 1'b0;
        sbox_ack_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            chk("post_done", done_out, 0);
            chk("post_err", err_out, 0);
            chk("post_busy", busy_out, 0);
            chk("post_wren", wr_en_out, 0);
        end
        o_nw = nw;
        o_cyc = cyc;
    endtask

    initial begin
        vec_t vt [6];
        bit g_done, g_err;
        int g_nw, g_cyc, k;

        vt[0] = '{conf: 0, d: 0, wh: -1, ab: -1, again: 0, e_done: 1, e_err: 0, e_nw: 44, e_cyc: 95};
        vt[1] = '{conf: 2, d: 0, wh: -1, ab: -1, again: 0, e_done: 1, e_err: 0, e_nw: 60, e_cyc: 126};
        vt[2] = '{conf: 1, d: 3, wh: -1, ab: -1, again: 0, e_done: 1, e_err: 0, e_nw: 52, e_cyc: 131};
        vt[3] = '{conf: 0, d: 0, wh: -1, ab: -1, again: 1, e_done: 1, e_err: 0, e_nw: 44, e_cyc: 95};
        vt[4] = '{conf: 0, d: 0, wh: 4,  ab: -1, again: 0, e_done: 0, e_err: 1, e_nw: 4,  e_cyc: 22};
        vt[5] = '{conf: 0, d: 0, wh: -1, ab: 20, again: 0, e_done: 0, e_err: 0, e_nw: 20, e_cyc: 42};

        rst_in = 1'b0;
        start_in = 1'b0;
        abort_in = 1'b0;
        conf_in = 2'd0;
        sbox_ack_in = 1'b0;
        repeat (2) @(negedge clk_in);
        chk_reset_outs("reset");
        rst_in = 1'b1;
        @(negedge clk_in);

        // Reserved configuration: single err pulse, no activity
        conf_in = 2'd3;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        chk("conf3_err", err_out, 1);
        chk("conf3_busy", busy_out, 0);
        chk("conf3_wren", wr_en_out, 0);
        @(negedge clk_in);
        chk("conf3_err_pulse", err_out, 0);
        chk("conf3_busy2", busy_out, 0);
        chk("conf3_wren2", wr_en_out, 0);

        for (int v = 0; v < 6; v++) begin
            run_sched(vt[v].conf, vt[v].d, vt[v].wh, vt[v].ab, vt[v].again, g_done, g_err, g_nw, g_cyc);
            chk($sformatf("vec%0d_done", v), g_done, vt[v].e_done);
            chk($sformatf("vec%0d_err", v), g_err, vt[v].e_err);
            chk($sformatf("vec%0d_writes", v), g_nw, vt[v].e_nw);
            chk($sformatf("vec%0d_cycles", v), g_cyc, vt[v].e_cyc);
        end

        // Async reset while waiting on the S-box
        @(negedge clk_in);
        conf_in = 2'd0;
        start_in = 1'b1;
        sbox_ack_in = 1'b0;
        @(negedge clk_in);
        start_in = 1'b0;
        k = 0;
        while (!sbox_req_out && k < 50) begin
            @(negedge clk_in);
            k++;
        end
        chk("rst_reach_wait", sbox_req_out, 1);
        #2 rst_in = 1'b0;
        #1 chk_reset_outs("midrst");
        @(negedge clk_in);
        chk("midrst_no_done", done_out, 0);
        rst_in = 1'b1;
        run_sched(0, 0, -1, -1, 0, g_done, g_err, g_nw, g_cyc);
        chk("after_rst_done", g_done, 1);
        chk("after_rst_writes", g_nw, 44);
        chk("after_rst_cycles", g_cyc, 95);

        // Random configurations, random ack delays and noise, occasional abort
        for (int r = 0; r < 6; r++) begin
            int conf, nk, last, ab;
            conf = $urandom_range(0, 2);
            nk = 4 + 2 * conf;
            last = 4 * (nk + 7) - 1;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(nk, last)) : -1;
            run_sched(conf, -1, -1, ab, 0, g_done, g_err, g_nw, g_cyc);
            chk($sformatf("rnd%0d_done", r), g_done, ab < 0);
            chk($sformatf("rnd%0d_err", r), g_err, 0);
            chk($sformatf("rnd%0d_writes", r), g_nw, (ab < 0) ? last + 1 : ab);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
